// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The package name is kept short because it is also used by the picker.
package rr_mux_pkg;
    typedef enum logic {IDLE, GRANT} state_t;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    // Valid only for one-hot or zero input; zero maps to index 0.
    function automatic logic [SEL_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) idx = idx | SEL_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/mux_4x1.sv
// 4-bit 4:1 multiplexer datapath shared by the arbiter's requesters.
module mux_4x1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end
endmodule

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick4
    import rr_mux_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] pick_o,
    output logic             any_o
);
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = '0;
        // Offset NREQ wraps back onto last_i itself, so it is scanned last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = last_i + SEL_W'(i);
            if (!any_o && req_i[idx]) begin
                pick_o = idx;
                any_o  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one mux_4x1 among four sources, with lockable
// bursts of up to MAX_HOLD beats and a registered valid/ready output.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    input  logic [3:0]       data_a,
    input  logic [3:0]       data_b,
    input  logic [3:0]       data_c,
    input  logic [3:0]       data_d,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       y,
    output logic             y_valid,
    input  logic             y_ready
);
    localparam int CNT_W = 4;

    state_t           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] last_q;
    logic [CNT_W-1:0] hold_q;
    logic [3:0]       y_q;
    logic             yv_q;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic [SEL_W-1:0] g;
    logic [3:0]       mux_y;
    logic             slot_free;

    rr_pick4 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any)
    );

    mux_4x1 u_mux (
        .a   (data_a),
        .b   (data_b),
        .c   (data_c),
        .d   (data_d),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign g         = onehot2idx(gnt_q);
    assign slot_free = !yv_q || y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NREQ - 1);
            hold_q  <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            // A take clears valid; a beat on the same edge overrides below.
            if (yv_q && y_ready) yv_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (any) begin
                        gnt_q   <= NREQ'(1) << pick;
                        sel_q   <= pick;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[g]) begin
                        gnt_q   <= '0;
                        last_q  <= g;
                        hold_q  <= '0;
                        state_q <= IDLE;
                    end else if (slot_free) begin
                        y_q  <= mux_y;
                        yv_q <= 1'b1;
                        if (!lock[g] || hold_q == CNT_W'(MAX_HOLD - 1)) begin
                            gnt_q   <= '0;
                            last_q  <= g;
                            hold_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = yv_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, lock;
    logic [3:0] data_a, data_b, data_c, data_d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] y;
    logic       y_valid;
    logic       y_ready;

    int checks   = 0;
    int failures = 0;

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; lock = '0; y_ready = 1'b1;
        data_a = 4'd0; data_b = 4'd3; data_c = 4'd4; data_d = 4'd6;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", sel); end
        checks++; if (y !== 4'd0 || y_valid !== 1'b0) begin failures++; $display("FAIL rst_y got=%0d/%b exp=0/0", y, y_valid); end
        // start a locked burst on source 2, then reset mid-burst
        req = 4'b0100; lock = 4'b0100;
        tick(); tick();
        checks++; if (y_valid !== 1'b1 || y !== 4'd4) begin failures++; $display("FAIL rst_preburst got=%0d/%b exp=4/1", y, y_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || sel !== 2'd0 || y !== 4'd0 || y_valid !== 1'b0) begin
            failures++; $display("FAIL rst_async got gnt=%b sel=%0d y=%0d v=%b exp 0000/0/0/0", gnt, sel, y, y_valid); end
        tick();
        checks++; if (gnt !== 4'b0000 || y_valid !== 1'b0) begin failures++; $display("FAIL rst_held got gnt=%b v=%b exp 0000/0", gnt, y_valid); end
        #2 rst_n = 1'b1;
        req = 4'b1111; lock = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
    endtask

    task automatic test_fairness();
        logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] ey [5] = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd0};
        logic [1:0] es [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111; lock = 4'b0000; y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt !== eg[i] || sel !== es[i]) begin
                failures++; $display("FAIL fair_gnt%0d got=%b/%0d exp=%b/%0d", i, gnt, sel, eg[i], es[i]); end
            tick();
            checks++; if (y !== ey[i] || y_valid !== 1'b1 || gnt !== 4'b0000) begin
                failures++; $display("FAIL fair_y%0d got y=%0d v=%b gnt=%b exp y=%0d v=1 gnt=0000", i, y, y_valid, gnt, ey[i]); end
        end
    endtask

    task automatic test_burst();
        do_reset();
        req = 4'b0100; lock = 4'b0100; y_ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL burst_gnt got=%b exp=0100", gnt); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (y !== 4'd4 || y_valid !== 1'b1) begin
                failures++; $display("FAIL burst_beat%0d got=%0d/%b exp=4/1", i, y, y_valid); end
            checks++; if (gnt !== ((i < 3) ? 4'b0100 : 4'b0000)) begin
                failures++; $display("FAIL burst_gnt%0d got=%b", i, gnt); end
        end
        tick();
        checks++; if (gnt !== 4'b0100 || y_valid !== 1'b0) begin
            failures++; $display("FAIL burst_regrant got gnt=%b v=%b exp 0100/0", gnt, y_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; lock = 4'b0010; y_ready = 1'b0;
        tick(); tick();
        checks++; if (y !== 4'd3 || y_valid !== 1'b1) begin failures++; $display("FAIL bp_first got=%0d/%b exp=3/1", y, y_valid); end
        data_b = 4'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (y !== 4'd3 || y_valid !== 1'b1 || gnt !== 4'b0010) begin
                failures++; $display("FAIL bp_hold%0d got y=%0d v=%b gnt=%b exp 3/1/0010", i, y, y_valid, gnt); end
        end
        y_ready = 1'b1; req = 4'b0000;
        tick();
        checks++; if (y_valid !== 1'b0 || y !== 4'd3 || gnt !== 4'b0000) begin
            failures++; $display("FAIL bp_take got y=%0d v=%b gnt=%b exp 3/0/0000", y, y_valid, gnt); end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0100; lock = 4'b0000; y_ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wd_gnt got=%b exp=0100", gnt); end
        req = 4'b1011;
        tick();
        checks++; if (gnt !== 4'b0000 || y_valid !== 1'b0) begin
            failures++; $display("FAIL wd_release got gnt=%b v=%b exp 0000/0", gnt, y_valid); end
        tick();
        checks++; if (gnt !== 4'b1000 || y_valid !== 1'b0) begin
            failures++; $display("FAIL wd_next got gnt=%b v=%b exp 1000/0", gnt, y_valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] eg [3] = '{4'b0001, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1001; lock = 4'b0000; y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (gnt !== eg[i]) begin failures++; $display("FAIL wrap_gnt%0d got=%b exp=%b", i, gnt, eg[i]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_burst();
        test_backpressure();
        test_withdraw();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
